// File: rtl/dot_product_engine_if.sv
// Operand/result bundle for the sequential dot-product engine.
// The master drives a job request; the slave (the engine) returns busy/done/result.
interface dot_product_engine_if #(
    parameter int N = 32,
    parameter int H = 10
);
    logic         start;
    logic [N-1:0] a_vec [H-1:0];
    logic [N-1:0] b_vec [H-1:0];
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         overflow;

    modport master (
        output start, a_vec, b_vec,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, a_vec, b_vec,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/dot_product_engine.sv
// Fixed-point dot product over H elements using P multiplier lanes per beat.
// Exact wide accumulation, then arithmetic rescale by Q and saturation to N bits.
module dot_product_engine #(
    parameter int Q = 15,
    parameter int N = 32,
    parameter int H = 10,
    parameter int P = 2
) (
    input logic                 clk,
    input logic                 rst,
    dot_product_engine_if.slave bus
);
    localparam int BEATS = (H + P - 1) / P;
    localparam int ACC_W = 2 * N + $clog2(H) + 1;
    localparam int PW    = 2 * N;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W - N + 1){1'b1}}, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINAL
    } state_t;

    state_t                   state_reg;
    logic [N-1:0]             a_reg [H-1:0];
    logic [N-1:0]             b_reg [H-1:0];
    logic signed [ACC_W-1:0]  acc_reg;
    logic [KW-1:0]            k_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     overflow_reg;
    logic [N-1:0]             result_reg;

    logic signed [PW-1:0]     prod [P-1:0];
    logic signed [ACC_W-1:0]  beat_sum;
    logic signed [ACC_W-1:0]  scaled;

    // Each lane muxes its operand pair first so only P multipliers are built.
    // Element indices past H-1 select nothing, which zero-pads the tail beat.
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_lane
            logic signed [N-1:0]  lane_a;
            logic signed [N-1:0]  lane_b;
            logic signed [PW-1:0] ext_a;
            logic signed [PW-1:0] ext_b;

            always_comb begin
                lane_a = '0;
                lane_b = '0;
                for (int e = 0; e < H; e++) begin
                    if (int'(k_reg) * P + gi == e) begin
                        lane_a = a_reg[e];
                        lane_b = b_reg[e];
                    end
                end
            end

            assign ext_a    = {{N{lane_a[N-1]}}, lane_a};
            assign ext_b    = {{N{lane_b[N-1]}}, lane_b};
            assign prod[gi] = ext_a * ext_b;
        end
    endgenerate

    always_comb begin
        beat_sum = '0;
        for (int j = 0; j < P; j++) begin
            beat_sum = beat_sum + {{(ACC_W - PW){prod[j][PW-1]}}, prod[j]};
        end
    end

    assign scaled = acc_reg >>> Q;

    // Operand capture carries no reset; it is only observable through a job.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == IDLE && bus.start) begin
            a_reg <= bus.a_vec;
            b_reg <= bus.b_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            k_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg <= acc_reg + beat_sum;
                    if (k_reg == KW'(BEATS - 1)) begin
                        state_reg <= FINAL;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                FINAL: begin
                    if (scaled > SAT_HI) begin
                        result_reg   <= {1'b0, {(N - 1){1'b1}}};
                        overflow_reg <= 1'b1;
                    end else if (scaled < SAT_LO) begin
                        result_reg   <= {1'b1, {(N - 1){1'b0}}};
                        overflow_reg <= 1'b1;
                    end else begin
                        result_reg   <= scaled[N-1:0];
                        overflow_reg <= 1'b0;
                    end
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.result   = result_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench: directed cases from the test plan plus randomized traffic,
// all compared against a cycle-level behavioural model of the engine.
module tb_dot_product_engine;
    localparam int Q     = 15;
    localparam int N     = 32;
    localparam int H     = 10;
    localparam int P     = 2;
    localparam int BEATS = (H + P - 1) / P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st3 = 1'b0;
    logic st1 = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    bit   cmp_en   = 1'b0;

    always #5 clk = ~clk;

    dot_product_engine_if #(.N(N), .H(H)) bus ();
    dot_product_engine_if #(.N(N), .H(H)) ifc3 ();
    dot_product_engine_if #(.N(N), .H(H)) ifc1 ();

    assign ifc3.start = st3;
    assign ifc3.a_vec = bus.a_vec;
    assign ifc3.b_vec = bus.b_vec;
    assign ifc1.start = st1;
    assign ifc1.a_vec = bus.a_vec;
    assign ifc1.b_vec = bus.b_vec;

    dot_product_engine #(.Q(Q), .N(N), .H(H), .P(P)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    dot_product_engine #(.Q(Q), .N(N), .H(H), .P(3)) dut_p3 (.clk(clk), .rst(rst), .bus(ifc3.slave));
    dot_product_engine #(.Q(Q), .N(N), .H(H), .P(1)) dut_p1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact signed sum of products, floor-shift by Q, clamp to N bits.
    function automatic logic [N:0] model_dot(input logic [N-1:0] a [H-1:0],
                                             input logic [N-1:0] b [H-1:0]);
        logic signed [127:0] s;
        logic signed [127:0] sc;
        s = '0;
        for (int i = 0; i < H; i++)
            s = s + 128'(longint'($signed(a[i])) * longint'($signed(b[i])));
        sc = s >>> Q;
        if (sc > 128'sh7FFF_FFFF)  return {1'b1, 32'h7FFF_FFFF};
        if (sc < -128'sh8000_0000) return {1'b1, 32'h8000_0000};
        return {1'b0, sc[N-1:0]};
    endfunction

    // Cycle-level model: a job accepted while idle keeps the engine busy for
    // BEATS+1 cycles, after which done pulses with the precomputed answer.
    logic         m_busy, m_done, m_ovf;
    logic [N-1:0] m_res;
    logic [N:0]   m_pend;
    int           m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_ovf <= 1'b0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    m_cnt  <= BEATS + 1;
                    m_busy <= 1'b1;
                    m_pend <= model_dot(bus.a_vec, bus.b_vec);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= m_pend[N-1:0];
                    m_ovf  <= m_pend[N];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("done", 64'(bus.done), 64'(m_done));
            check("result", 64'(bus.result), 64'(m_res));
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
            if (bus.done) done_cnt++;
        end
    end

    task automatic set_all(input logic [N-1:0] av, input logic [N-1:0] bv);
        for (int i = 0; i < H; i++) begin
            bus.a_vec[i] = av;
            bus.b_vec[i] = bv;
        end
    endtask

    task automatic run_job(output int lat);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_lane(input int which, output int lat, output logic [N-1:0] res);
        if (which == 3) st3 = 1'b1; else st1 = 1'b1;
        @(negedge clk);
        st3 = 1'b0;
        st1 = 1'b0;
        lat = 0;
        while (!(which == 3 ? ifc3.done : ifc1.done) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = (which == 3) ? ifc3.result : ifc1.result;
    endtask

    function automatic logic [N-1:0] rnd_word(input int mode);
        case (mode)
            0:       return N'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
            1:       return $urandom;
            default: return ($urandom_range(0, 2) == 0) ? $urandom : '0;
        endcase
    endfunction

    initial begin
        int           lat;
        int           dc0;
        logic [N-1:0] res;

        bus.start = 1'b0;
        set_all('0, '0);
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // 1.0 * 0.5 summed ten times
        set_all(32'h0000_8000, 32'h0000_4000);
        check("model_ones", 64'(model_dot(bus.a_vec, bus.b_vec)), 64'h0_0002_8000);
        run_job(lat);
        check("lat_p2", 64'(lat), 64'd6);
        check("res_ones", 64'(bus.result), 64'h0002_8000);
        check("ovf_ones", 64'(bus.overflow), 64'd0);
        @(negedge clk);

        for (int i = 0; i < H; i++) bus.b_vec[i] = (i % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
        run_job(lat);
        check("res_alt", 64'(bus.result), 64'h0);
        @(negedge clk);

        set_all('0, '0);
        bus.a_vec[0] = 32'hFFFF_4000;
        bus.b_vec[0] = 32'h0001_0000;
        check("model_sparse", 64'(model_dot(bus.a_vec, bus.b_vec)), 64'h0_FFFE_8000);
        run_job(lat);
        check("res_sparse", 64'(bus.result), 64'hFFFE_8000);
        @(negedge clk);

        set_all(32'h7FFF_FFFF, 32'h0001_0000);
        run_job(lat);
        check("res_sat_hi", 64'(bus.result), 64'h7FFF_FFFF);
        check("ovf_sat_hi", 64'(bus.overflow), 64'd1);
        @(negedge clk);
        set_all(32'h7FFF_FFFF, 32'hFFFF_0000);
        check("model_sat_lo", 64'(model_dot(bus.a_vec, bus.b_vec)), 64'h1_8000_0000);
        run_job(lat);
        check("res_sat_lo", 64'(bus.result), 64'h8000_0000);
        check("ovf_sat_lo", 64'(bus.overflow), 64'd1);
        @(negedge clk);
        set_all(32'h0000_8000, 32'h0000_4000);
        run_job(lat);
        check("ovf_cleared", 64'(bus.overflow), 64'd0);
        @(negedge clk);

        set_all('0, '0);
        bus.a_vec[0] = 32'h0000_0001;
        bus.b_vec[0] = 32'h0000_4000;
        run_job(lat);
        check("res_floor_pos", 64'(bus.result), 64'h0);
        @(negedge clk);
        bus.b_vec[0] = 32'hFFFF_C000;
        check("model_floor_neg", 64'(model_dot(bus.a_vec, bus.b_vec)), 64'h0_FFFF_FFFF);
        run_job(lat);
        check("res_floor_neg", 64'(bus.result), 64'hFFFF_FFFF);
        @(negedge clk);

        // start while busy is ignored; inputs scrambled right after accept
        set_all(32'h0000_8000, 32'h0000_4000);
        dc0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < H; i++) begin
            bus.a_vec[i] = $urandom;
            bus.b_vec[i] = $urandom;
        end
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("busy_start_one_done", 64'(done_cnt - dc0), 64'd1);
        check("res_captured", 64'(bus.result), 64'h0002_8000);
        @(negedge clk);

        // back-to-back: second start lands in the cycle after done
        set_all(32'h0000_8000, 32'h0000_4000);
        run_job(lat);
        set_all('0, '0);
        bus.a_vec[0] = 32'hFFFF_4000;
        bus.b_vec[0] = 32'h0001_0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_gap", 64'(lat), 64'd7);
        check("b2b_res", 64'(bus.result), 64'hFFFE_8000);
        @(negedge clk);

        // reset three cycles after accept abandons the job
        set_all(32'h0000_8000, 32'h0000_4000);
        dc0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_result", 64'(bus.result), 64'h0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - dc0), 64'd0);

        run_lane(3, lat, res);
        check("lat_p3", 64'(lat), 64'd5);
        check("res_p3", 64'(res), 64'h0002_8000);
        @(negedge clk);
        run_lane(1, lat, res);
        check("lat_p1", 64'(lat), 64'd11);
        check("res_p1", 64'(res), 64'h0002_8000);
        @(negedge clk);

        for (int c = 0; c < 600; c++) begin
            int mode;
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            mode      = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < H; i++) begin
                    bus.a_vec[i] = rnd_word(mode);
                    bus.b_vec[i] = rnd_word(mode);
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
